// File: rtl/sensor_pkg.sv
// ---------------------------------------------------------------------------
// sensor_pkg
// Shared constants and types for the sensor debounce block.
//   NUM_SENSORS : width of the sensor vector
//   state_e     : control FSM states (WARMUP, RUN)
//   cnt_width() : bits needed for a counter that must hold values 0..n
// ---------------------------------------------------------------------------
package sensor_pkg;

  localparam int NUM_SENSORS = 4;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } state_e;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
// One sensor bit: 2-flop synchronizer, consecutive-tick counter and the
// debounced stable bit.
//   clk, n_rst   : clock, asynchronous active-low reset
//   raw_i        : unsynchronized sensor level
//   sample_en_i  : sample tick; state advances only when high
//   warmup_i     : high while the block warms up; the stable bit then
//                  tracks the synchronized level directly
//   stable_o     : registered debounced level
//   update_o     : combinational strobe, high on the tick where stable_o
//                  will change (the top level registers it into change)
// ---------------------------------------------------------------------------
module debounce_channel
  import sensor_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic raw_i,
  input  logic sample_en_i,
  input  logic warmup_i,
  output logic stable_o,
  output logic update_o
);

  localparam int                CNT_W    = cnt_width(DEBOUNCE_CNT);
  // Counter value on the tick before acceptance; reaching DEBOUNCE_CNT is
  // never stored, the bit flips and the counter clears instead.
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic             meta_q;
  logic             sync_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: synchronizer flops are reset too, so a reset mid-debounce cannot
  // leave a stale level in the pipeline that later looks like an edge.
  // NOTE: sequential state uses non-blocking assignments so meta_q -> sync_q
  // really is two flops and not one collapsed wire.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    update_o = 1'b0;
    if (sample_en_i) begin
      if (warmup_i) begin
        stable_d = sync_q;
        cnt_d    = '0;
      end else if (sync_q != stable_q) begin
        if (cnt_q == CNT_LAST) begin
          stable_d = sync_q;
          cnt_d    = '0;
          update_o = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        // Any tick that agrees with the stable level breaks the run.
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/sensor_debounce.sv
// ---------------------------------------------------------------------------
// sensor_debounce
// Debounces NUM_SENSORS raw sensor levels. After reset a warm-up phase of
// DEBOUNCE_CNT sample ticks copies the synchronized levels straight into
// sensors; afterwards each bit changes only after DEBOUNCE_CNT consecutive
// ticks of disagreement.
//   clk           : system clock
//   n_rst         : asynchronous active-low reset
//   sensors_raw   : unsynchronized, possibly bouncing levels
//   sample_en     : sample tick
//   sensors       : registered debounced vector
//   sensors_valid : high once warm-up has completed
//   change        : one-cycle pulse in the first cycle a new sensors value
//                   is visible
// ---------------------------------------------------------------------------
module sensor_debounce
  import sensor_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [NUM_SENSORS-1:0] sensors_raw,
  input  logic                   sample_en,
  output logic [NUM_SENSORS-1:0] sensors,
  output logic                   sensors_valid,
  output logic                   change
);

  localparam int               WARM_W    = cnt_width(DEBOUNCE_CNT);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(DEBOUNCE_CNT - 1);

  state_e                  state_q;
  logic [WARM_W-1:0]       warm_cnt_q;
  logic                    sensors_valid_q;
  logic                    change_q;
  logic                    warmup;
  logic [NUM_SENSORS-1:0]  update;

  assign warmup = (state_q == WARMUP);

  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_ch (
      .clk         (clk),
      .n_rst       (n_rst),
      .raw_i       (sensors_raw[i]),
      .sample_en_i (sample_en),
      .warmup_i    (warmup),
      .stable_o    (sensors[i]),
      .update_o    (update[i])
    );
  end

  // Control FSM with registered outputs. sensors_valid is set on the same
  // edge that enters RUN, so it is high from the following cycle onward.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q         <= WARMUP;
      warm_cnt_q      <= '0;
      sensors_valid_q <= 1'b0;
      change_q        <= 1'b0;
    end else begin
      case (state_q)
        WARMUP: begin
          change_q <= 1'b0;
          if (sample_en) begin
            warm_cnt_q <= warm_cnt_q + 1'b1;
            if (warm_cnt_q == WARM_LAST) begin
              state_q         <= RUN;
              sensors_valid_q <= 1'b1;
            end
          end
        end
        RUN: begin
          // Strobes coincide with the edge that updates sensors, so the
          // registered pulse lines up with the new value. Several channels
          // flipping together still give a single pulse.
          change_q <= |update;
        end
      endcase
    end
  end

  assign sensors_valid = sensors_valid_q;
  assign change        = change_q;

endmodule

// File: tb/tb_sensor_debounce.sv
// ---------------------------------------------------------------------------
// tb_sensor_debounce
// Directed scenarios followed by randomized stimulus, all compared every
// cycle against a behavioural model: raw levels are seen two edges late,
// warm-up copies them for DEBOUNCE_CNT ticks, then a bit flips after
// DEBOUNCE_CNT consecutive disagreeing ticks.
// ---------------------------------------------------------------------------
module tb_sensor_debounce;
  import sensor_pkg::*;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       sample_en;
  logic [3:0] sensors_raw;
  logic [3:0] sensors;
  logic       sensors_valid;
  logic       change;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [3:0] m_sens;
  logic [3:0] m_d1, m_d2;   // raw levels seen one and two edges ago
  bit         m_valid;
  bit         m_change;
  int         m_warm;
  int         m_run[4];

  always #5 clk = ~clk;

  sensor_debounce #(.DEBOUNCE_CNT(N)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .sensors_raw   (sensors_raw),
    .sample_en     (sample_en),
    .sensors       (sensors),
    .sensors_valid (sensors_valid),
    .change        (change)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_sens   = '0;
    m_d1     = '0;
    m_d2     = '0;
    m_valid  = 1'b0;
    m_change = 1'b0;
    m_warm   = 0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
  endtask

  task automatic model_step();
    logic [3:0] synced;
    synced   = m_d2;
    m_change = 1'b0;
    if (sample_en) begin
      if (!m_valid) begin
        m_sens = synced;
        m_warm++;
        if (m_warm == N) m_valid = 1'b1;
      end else begin
        for (int ch = 0; ch < 4; ch++) begin
          if (synced[ch] !== m_sens[ch]) begin
            m_run[ch]++;
            if (m_run[ch] == N) begin
              m_sens[ch] = synced[ch];
              m_run[ch]  = 0;
              m_change   = 1'b1;
            end
          end else begin
            m_run[ch] = 0;
          end
        end
      end
    end
    m_d2 = m_d1;
    m_d1 = sensors_raw;
  endtask

  // One clock edge: advance the model, then compare 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (!n_rst) model_clear();
    else        model_step();
    #1;
    check("sensors", sensors, m_sens);
    check("valid",   sensors_valid, m_valid);
    check("change",  change, m_change);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic apply_reset(input int cycles);
    n_rst = 1'b0;
    #1;
    model_clear();
    check("rst_sensors", sensors, 0);
    check("rst_valid",   sensors_valid, 0);
    check("rst_change",  change, 0);
    repeat (cycles) tick();
    n_rst = 1'b1;
  endtask

  initial begin
    int lat;
    int pulses;
    int idx;

    n_rst       = 1'b0;
    sample_en   = 1'b1;
    sensors_raw = 4'b0101;
    model_clear();
    #2;

    // Reset and warm-up with a constant 0101 input
    apply_reset(2);
    lat    = -1;
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (change) pulses++;
      if (sensors_valid) begin
        lat = k;
        break;
      end
    end
    check("warm_ticks",   lat, 4);
    check("warm_sensors", sensors, 4'b0101);
    check("warm_change",  pulses, 0);

    // Glitch rejection: bit1 high for only 3 cycles
    sensors_raw[1] = 1'b1;
    repeat (3) tick();
    sensors_raw[1] = 1'b0;
    pulses = 0;
    repeat (8) begin
      tick();
      if (change) pulses++;
    end
    check("glitch_sensors", sensors, 4'b0101);
    check("glitch_change",  pulses, 0);

    // Clean held edge on bit3: visible exactly 6 edges after the raw edge
    sensors_raw[3] = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (sensors[3]) begin
        lat = k;
        break;
      end
    end
    check("edge_lat",    lat, 6);
    check("edge_change", change, 1);
    tick();
    check("edge_change_once", change, 0);

    // Tick gating: sample_en every other cycle, bit0 falls
    sensors_raw[0] = 1'b0;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      sample_en = (k % 2 == 1);
      tick();
      if (!sensors[0]) begin
        lat = k;
        break;
      end
    end
    check("gate_lat", lat, 9);
    sample_en = 1'b1;

    // Simultaneous change on bits 1 and 2: one pulse
    sensors_raw[1] = 1'b1;
    sensors_raw[2] = 1'b0;
    pulses = 0;
    repeat (12) begin
      tick();
      if (change) pulses++;
    end
    check("simul_pulses",  pulses, 1);
    check("simul_sensors", sensors, 4'b1010);

    // Mid-debounce reset: bit0 counter has reached 3 after 5 edges
    sensors_raw[0] = 1'b1;
    repeat (5) tick();
    check("pre_rst_sensors", sensors, 4'b1010);
    apply_reset(2);
    lat    = -1;
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (change) pulses++;
      if (sensors_valid) begin
        lat = k;
        break;
      end
    end
    check("rewarm_ticks", lat, 4);
    repeat (8) begin
      tick();
      if (change) pulses++;
    end
    check("rewarm_sensors", sensors, 4'b1011);
    check("rewarm_change",  pulses, 0);

    // Randomized traffic: sparse bit flips, random ticks, rare resets
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        idx = $urandom_range(0, 3);
        sensors_raw[idx] = ~sensors_raw[idx];
      end
      sample_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 599) == 0) apply_reset(2);
      else                              tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
